uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Shares one UART transmitter between several byte producers. Each cycle the block is idle, it picks one pending requester and latches that requester's byte. It then fires a single-cycle start pulse into the transmitter and holds off all requesters until the frame and an inter-frame gap have elapsed. It sits between the producers (command echo, status reporter, debug tap, …) and the transmitter's byte/start inputs.

## Interface
- NUM_REQ, 4, number of requesters (1..16)
- FRAME_CYCLES, 10, clock cycles one frame occupies on the line, counted from the start-pulse cycle (≥2)
- GAP_CYCLES, 1, idle cycles enforced after each frame (≥0)
- clock  input  1  single clock, all logic on rising edge
- reset  input  1  asynchronous, active-high
- req_valid  input  NUM_REQ  bit i: requester i has a byte pending
- req_data  input  8*NUM_REQ  byte of requester i at bits [8i+7:8i]
- req_ready  output  NUM_REQ  one-hot accept; byte i taken when req_valid[i] & req_ready[i]
- tx_byte  output  8  byte presented to transmitter, stable for the whole frame
- tx_start  output  1  one-cycle start pulse to transmitter
- grant_id  output  $clog2(NUM_REQ) (min 1)  index of last accepted requester
- busy  output  1  high from start pulse to end of gap

## Operation
- States: IDLE, START, SEND, GAP.
- IDLE:
  - busy=0.
  - If any req_valid, req_ready is driven combinationally to the winner's one-hot.
  - At the clock edge: tx_byte ← winner's data, grant_id ← winner index, state → START.
  - If no req_valid, req_ready=0 and the state stays IDLE.
- START:
  - tx_start=1, busy=1, req_ready=0.
  - Counter loaded with FRAME_CYCLES-1; state → SEND.
- SEND:
  - Counter decrements each cycle.
  - At 0: → GAP with counter loaded to GAP_CYCLES-1, or → IDLE if GAP_CYCLES=0.
- GAP:
  - Counter decrements; at 0 → IDLE.
- Arbitration is round-robin (default; see Configuration):
  - Priority pointer p; the search order is p, p+1, … mod NUM_REQ.
  - On acceptance of i, p ← (i+1) mod NUM_REQ.
  - p changes only on acceptance.
- Requester protocol:
  - Hold req_valid and req_data stable until accepted.
  - Dropping req_valid before acceptance is legal: no grant, no penalty.
  - Requests arriving while busy wait; they are never lost or reordered per requester.
- NUM_REQ=1: the arbiter degenerates to a pass-through with pacing; p stays 0.
- Counter width: $clog2(max(FRAME_CYCLES, GAP_CYCLES)+1). No wrap occurs since counters are reloaded before use.

## Timing
- Reset values: req_ready=0, tx_start=0, tx_byte=8'h00, grant_id=0, busy=0, state=IDLE, p=0.
- Request with req_valid rising in IDLE at cycle N:
  - req_ready high in N.
  - tx_start high in N+1 only.
  - tx_byte valid from N+1 until the next acceptance.
  - busy high N+1 … N+FRAME_CYCLES+GAP_CYCLES.
  - Next acceptance is possible at cycle N+1+FRAME_CYCLES+GAP_CYCLES.
- Back-to-back throughput: one byte per FRAME_CYCLES+GAP_CYCLES+1 cycles.
- Simultaneous requests: exactly one req_ready bit is ever high; winner per pointer.
- Reset asserted mid-frame:
  - All outputs go to reset values immediately, without waiting for a clock edge.
  - The frame in flight is abandoned.
  - No tx_start while reset is high, nor in the first cycle after release.
  - The first acceptance is possible in the first cycle after reset deasserts.

## Configuration
- UART_TX_ARB_RR_EN defined: round-robin arbitration as above.
- Undefined: fixed priority, lowest index wins. The pointer register is removed and p is constant 0. Starvation of high indices is permitted.

## Structure
- Package uart_pkg holds:
  - the state enum (IDLE, START, SEND, GAP)
  - the byte width constant (8)
  - the parameter legality checks (elaboration-time assertions).
- Sub-module rr_pick computes the one-hot winner from the request vector and pointer, purely combinationally. It takes the fixed-priority path when the macro is absent.
- FSM, counter and output registers live in uart_tx_arbiter.

## Test plan
- Single request: reset, hold req_valid[2] with data 8'hA5 → req_ready=4'b0100 in the same cycle; tx_start for exactly 1 cycle next; tx_byte=8'hA5; busy for 11 cycles (defaults).
- All four requesting continuously, bytes 8'h10..8'h13 → accept order 0,1,2,3,0 with RR_EN; 0,0,0 without; acceptances spaced exactly 12 cycles.
- Request arriving during busy → no req_ready until state returns to IDLE; accepted in the first IDLE cycle.
- req_valid[1] pulsed for one cycle while busy, then dropped → no grant to 1; p unchanged.
- Reset asserted 5 cycles into SEND → busy/tx_start/tx_byte go to 0 without a clock edge. After release, a pending req[3] is accepted in the first cycle with grant_id=3 (p=0 search).
- GAP_CYCLES=0 build: back-to-back requests → tx_start pulses exactly FRAME_CYCLES+1 cycles apart.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and elaboration helpers for the UART transmit arbiter.
// Holds the FSM state enum, the byte width and the parameter legality check
// that uart_tx_arbiter evaluates at elaboration time.
package uart_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SEND  = 2'd2,
    GAP   = 2'd3
  } state_e;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int unsigned id_width(input int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  // Counter must hold the larger of the frame and gap lengths.
  function automatic int unsigned cnt_width(input int unsigned frame_cycles,
                                            input int unsigned gap_cycles);
    int unsigned m;
    m = (frame_cycles > gap_cycles) ? frame_cycles : gap_cycles;
    return $clog2(m + 1);
  endfunction

  // Legal configuration: 1..16 requesters, frames of at least two cycles.
  function automatic bit params_ok(input int unsigned num_req,
                                   input int unsigned frame_cycles);
    return (num_req >= 1) && (num_req <= 16) && (frame_cycles >= 2);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// One-hot winner selection among pending requesters, purely combinational.
// With UART_TX_ARB_RR_EN defined the search starts at ptr and wraps
// (round-robin); otherwise the lowest pending index wins and there is no
// pointer input.
// Ports:
//   req       - pending request vector
//   ptr       - search start index (round-robin build only)
//   grant     - one-hot winner, zero when nothing is pending
//   grant_idx - binary index of the winner
//   any_req   - at least one request pending
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
`ifdef UART_TX_ARB_RR_EN
  input  logic [ID_W-1:0]    ptr,
`endif
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_req
);

  logic            found;
  int              idx;
  logic [ID_W-1:0] sel;

  // First pending requester in search order wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    sel       = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
`ifdef UART_TX_ARB_RR_EN
      idx = (int'(ptr) + k) % int'(NUM_REQ);
`else
      idx = k;
`endif
      sel = ID_W'(idx);
      if (!found && req[sel]) begin
        found      = 1'b1;
        grant[sel] = 1'b1;
        grant_idx  = sel;
      end
    end
    any_req = found;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte producers. In IDLE one
// pending requester is accepted, its byte is latched onto tx_byte and a
// single-cycle tx_start follows; all requesters are then held off for the
// frame plus an inter-frame gap.
// Build option: UART_TX_ARB_RR_EN selects round-robin arbitration; without it
// the lowest pending index always wins.
// Ports:
//   clock, reset - rising-edge clock, asynchronous active-high reset
//   req_valid    - per-requester byte pending
//   req_data     - requester i byte at [8i+7:8i]
//   req_ready    - one-hot accept, combinational, only in IDLE
//   tx_byte      - byte for the transmitter, held until the next acceptance
//   tx_start     - one-cycle start pulse
//   grant_id     - index of the last accepted requester
//   busy         - high from the start pulse to the end of the gap
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned FRAME_CYCLES = 10,
  parameter int unsigned GAP_CYCLES   = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0]     req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [BYTE_W-1:0]             tx_byte,
  output logic                          tx_start,
  output logic [id_width(NUM_REQ)-1:0]  grant_id,
  output logic                          busy
);

  localparam int unsigned ID_W       = id_width(NUM_REQ);
  localparam int unsigned CNT_W      = cnt_width(FRAME_CYCLES, GAP_CYCLES);
  localparam int unsigned FRAME_LOAD = FRAME_CYCLES - 1;
  localparam int unsigned GAP_LOAD   = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  if (!params_ok(NUM_REQ, FRAME_CYCLES)) begin : g_bad_params
    $error("uart_tx_arbiter: NUM_REQ must be 1..16 and FRAME_CYCLES >= 2");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BYTE_W-1:0]  byte_d;
  logic [ID_W-1:0]    gid_d;
  logic               tx_start_d;
  logic               busy_d;

  logic [NUM_REQ-1:0] pick_grant;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_any;

`ifdef UART_TX_ARB_RR_EN
  logic [ID_W-1:0]    ptr_q, ptr_d;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req       (req_valid),
`ifdef UART_TX_ARB_RR_EN
    .ptr       (ptr_q),
`endif
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .any_req   (pick_any)
  );

  // Accept only while idle; gated by reset so it is low during reset.
  assign req_ready = (state_q == IDLE && !reset) ? pick_grant : '0;

  // Next state, counter and output values. The counter is loaded at
  // acceptance and the START cycle counts as the first frame cycle, so
  // START + SEND together last exactly FRAME_CYCLES.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    byte_d  = tx_byte;
    gid_d   = grant_id;
`ifdef UART_TX_ARB_RR_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = START;
          cnt_d   = CNT_W'(FRAME_LOAD);
          byte_d  = req_data[32'(pick_idx)*BYTE_W +: BYTE_W];
          gid_d   = pick_idx;
`ifdef UART_TX_ARB_RR_EN
          ptr_d   = ID_W'((32'(pick_idx) + 32'd1) % NUM_REQ);
`endif
        end
      end
      START: begin
        state_d = SEND;
        cnt_d   = cnt_q - CNT_W'(1);
      end
      SEND: begin
        if (cnt_q == '0) begin
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d = GAP;
            cnt_d   = CNT_W'(GAP_LOAD);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
    tx_start_d = (state_d == START);
    busy_d     = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tx_byte  <= '0;
      grant_id <= '0;
      tx_start <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tx_byte  <= byte_d;
      grant_id <= gid_d;
      tx_start <= tx_start_d;
      busy     <= busy_d;
    end
  end

`ifdef UART_TX_ARB_RR_EN
  // Priority pointer moves only on acceptance.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`endif

endmodule
